// File: rtl/operand_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : operand_hazard_unit
// Brief    : D-stage operand forwarding, Tuse/Tnew stall detection and a
//            shadow E/M/W pipeline that drives the GRF write port.
// Revision : 1.0 - initial release
// ============================================================================
module operand_hazard_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_pc,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic [4:0]        d_dst,
    input  logic [1:0]        d_tnew,

    output logic [4:0]        grf_raddr1,
    output logic [4:0]        grf_raddr2,
    input  logic [DATA_W-1:0] grf_rdata1,
    input  logic [DATA_W-1:0] grf_rdata2,

    input  logic [DATA_W-1:0] e_res,
    input  logic [DATA_W-1:0] m_res,
    input  logic [DATA_W-1:0] w_res,

    output logic [DATA_W-1:0] d_rs_val,
    output logic [DATA_W-1:0] d_rt_val,
    output logic              stall,

    output logic              e_valid,
    output logic [DATA_W-1:0] e_pc,
    output logic [4:0]        e_dst,
    output logic [1:0]        e_tnew,
    output logic [DATA_W-1:0] e_rs_val,
    output logic [DATA_W-1:0] e_rt_val,

    output logic              w_reg_write,
    output logic [4:0]        w_waddr,
    output logic [DATA_W-1:0] w_pc
);

    // Shadow pipeline state
    logic              r_e_valid, r_m_valid, r_w_valid;
    logic [DATA_W-1:0] r_e_pc, r_m_pc, r_w_pc;
    logic [4:0]        r_e_dst, r_m_dst, r_w_dst;
    logic [1:0]        r_e_tnew, r_m_tnew;
    logic [4:0]        r_e_rs_num, r_e_rt_num;
    logic [DATA_W-1:0] r_e_rs_raw, r_e_rt_raw;

    logic w_e_hit_rs, w_m_hit_rs, w_w_hit_rs;
    logic w_e_hit_rt, w_m_hit_rt, w_w_hit_rt;
    logic w_em_hit_rs, w_ew_hit_rs, w_em_hit_rt, w_ew_hit_rt;
    logic w_conf_rs, w_conf_rt;
    logic w_accept;

    function automatic logic stage_hit(input logic valid, input logic [4:0] dst,
                                       input logic [4:0] r);
        return valid && (dst == r) && (r != 5'd0);
    endfunction

    // A Tuse of 2 or 3 both mean "not consumed before M", so only bit 1 matters.
    function automatic logic conflict(input logic [1:0] tuse,
                                      input logic e_hit, input logic [1:0] e_tn,
                                      input logic m_hit, input logic [1:0] m_tn);
        if (tuse[1])
            return 1'b0;
        return (e_hit && (e_tn > tuse)) || (m_hit && (m_tn > tuse));
    endfunction

    function automatic logic [DATA_W-1:0] fwd_d(input logic [4:0] r,
                                                input logic e_ok, input logic m_ok,
                                                input logic w_ok,
                                                input logic [DATA_W-1:0] grf,
                                                input logic [DATA_W-1:0] ev,
                                                input logic [DATA_W-1:0] mv,
                                                input logic [DATA_W-1:0] wv);
        if (r == 5'd0)
            return '0;
        if (e_ok)
            return ev;
        if (m_ok)
            return mv;
        if (w_ok)
            return wv;
        return grf;
    endfunction

    assign grf_raddr1 = d_rs;
    assign grf_raddr2 = d_rt;

    assign w_e_hit_rs = stage_hit(r_e_valid, r_e_dst, d_rs);
    assign w_m_hit_rs = stage_hit(r_m_valid, r_m_dst, d_rs);
    assign w_w_hit_rs = stage_hit(r_w_valid, r_w_dst, d_rs);
    assign w_e_hit_rt = stage_hit(r_e_valid, r_e_dst, d_rt);
    assign w_m_hit_rt = stage_hit(r_m_valid, r_m_dst, d_rt);
    assign w_w_hit_rt = stage_hit(r_w_valid, r_w_dst, d_rt);

    assign d_rs_val = fwd_d(d_rs, w_e_hit_rs && (r_e_tnew == 2'd0),
                            w_m_hit_rs && (r_m_tnew == 2'd0), w_w_hit_rs,
                            grf_rdata1, e_res, m_res, w_res);
    assign d_rt_val = fwd_d(d_rt, w_e_hit_rt && (r_e_tnew == 2'd0),
                            w_m_hit_rt && (r_m_tnew == 2'd0), w_w_hit_rt,
                            grf_rdata2, e_res, m_res, w_res);

    assign w_conf_rs = conflict(d_tuse_rs, w_e_hit_rs, r_e_tnew, w_m_hit_rs, r_m_tnew);
    assign w_conf_rt = conflict(d_tuse_rt, w_e_hit_rt, r_e_tnew, w_m_hit_rt, r_m_tnew);
    assign stall     = d_valid && (w_conf_rs || w_conf_rt);
    assign w_accept  = d_valid && !stall;

    // E operands pick up results that became ready after the D-stage read.
    assign w_em_hit_rs = stage_hit(r_m_valid, r_m_dst, r_e_rs_num);
    assign w_ew_hit_rs = stage_hit(r_w_valid, r_w_dst, r_e_rs_num);
    assign w_em_hit_rt = stage_hit(r_m_valid, r_m_dst, r_e_rt_num);
    assign w_ew_hit_rt = stage_hit(r_w_valid, r_w_dst, r_e_rt_num);

    assign e_rs_val = (w_em_hit_rs && (r_m_tnew == 2'd0)) ? m_res :
                      w_ew_hit_rs ? w_res : r_e_rs_raw;
    assign e_rt_val = (w_em_hit_rt && (r_m_tnew == 2'd0)) ? m_res :
                      w_ew_hit_rt ? w_res : r_e_rt_raw;

    assign e_valid = r_e_valid;
    assign e_pc    = r_e_pc;
    assign e_dst   = r_e_dst;
    assign e_tnew  = r_e_tnew;

    // The GRF is also being reset, so no write is allowed during reset.
    assign w_reg_write = r_w_valid && (r_w_dst != 5'd0) && !reset;
    assign w_waddr     = r_w_dst;
    assign w_pc        = r_w_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_valid  <= 1'b0;
            r_e_pc     <= '0;
            r_e_dst    <= 5'd0;
            r_e_tnew   <= 2'd0;
            r_e_rs_num <= 5'd0;
            r_e_rt_num <= 5'd0;
            r_e_rs_raw <= '0;
            r_e_rt_raw <= '0;
            r_m_valid  <= 1'b0;
            r_m_pc     <= '0;
            r_m_dst    <= 5'd0;
            r_m_tnew   <= 2'd0;
            r_w_valid  <= 1'b0;
            r_w_pc     <= '0;
            r_w_dst    <= 5'd0;
        end else begin
            if (w_accept) begin
                r_e_valid  <= 1'b1;
                r_e_pc     <= d_pc;
                r_e_dst    <= d_dst;
                r_e_tnew   <= d_tnew;
                r_e_rs_num <= d_rs;
                r_e_rt_num <= d_rt;
                r_e_rs_raw <= d_rs_val;
                r_e_rt_raw <= d_rt_val;
            end else begin
                r_e_valid  <= 1'b0;
                r_e_pc     <= '0;
                r_e_dst    <= 5'd0;
                r_e_tnew   <= 2'd0;
                r_e_rs_num <= 5'd0;
                r_e_rt_num <= 5'd0;
                r_e_rs_raw <= '0;
                r_e_rt_raw <= '0;
            end
            r_m_valid <= r_e_valid;
            r_m_pc    <= r_e_pc;
            r_m_dst   <= r_e_dst;
            r_m_tnew  <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
            r_w_valid <= r_m_valid;
            r_w_pc    <= r_m_pc;
            r_w_dst   <= r_m_dst;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_hazard_unit
// Brief    : Directed scoreboard bench for operand_hazard_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_hazard_unit;

    localparam int DW = 32;

    localparam int SEL_STALL  = 0;
    localparam int SEL_WRE    = 1;
    localparam int SEL_EVALID = 2;
    localparam int SEL_ERS    = 3;
    localparam int SEL_ERT    = 4;
    localparam int SEL_DRS    = 5;
    localparam int SEL_DRT    = 6;
    localparam int SEL_WADDR  = 7;
    localparam int SEL_WPC    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          d_valid;
    logic [DW-1:0] d_pc;
    logic [4:0]    d_rs, d_rt, d_dst;
    logic [1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
    logic [4:0]    grf_raddr1, grf_raddr2;
    logic [DW-1:0] grf_rdata1, grf_rdata2;
    logic [DW-1:0] e_res, m_res, w_res;
    logic [DW-1:0] d_rs_val, d_rt_val;
    logic          stall;
    logic          e_valid;
    logic [DW-1:0] e_pc;
    logic [4:0]    e_dst;
    logic [1:0]    e_tnew;
    logic [DW-1:0] e_rs_val, e_rt_val;
    logic          w_reg_write;
    logic [4:0]    w_waddr;
    logic [DW-1:0] w_pc;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } obs_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] pc;
    } wb_t;

    obs_t        obs_q[$];
    wb_t         wb_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mon_act;
    wb_t         mon_wb;

    operand_hazard_unit #(.DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_pc       (d_pc),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .grf_raddr1 (grf_raddr1),
        .grf_raddr2 (grf_raddr2),
        .grf_rdata1 (grf_rdata1),
        .grf_rdata2 (grf_rdata2),
        .e_res      (e_res),
        .m_res      (m_res),
        .w_res      (w_res),
        .d_rs_val   (d_rs_val),
        .d_rt_val   (d_rt_val),
        .stall      (stall),
        .e_valid    (e_valid),
        .e_pc       (e_pc),
        .e_dst      (e_dst),
        .e_tnew     (e_tnew),
        .e_rs_val   (e_rs_val),
        .e_rt_val   (e_rt_val),
        .w_reg_write(w_reg_write),
        .w_waddr    (w_waddr),
        .w_pc       (w_pc)
    );

    always #5 clk = ~clk;

    // Stand-in register file: register n reads as 0x1000_0000 + n.
    assign grf_rdata1 = 32'h1000_0000 + {27'd0, grf_raddr1};
    assign grf_rdata2 = 32'h1000_0000 + {27'd0, grf_raddr2};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SEL_STALL:  return {31'd0, stall};
            SEL_WRE:    return {31'd0, w_reg_write};
            SEL_EVALID: return {31'd0, e_valid};
            SEL_ERS:    return e_rs_val;
            SEL_ERT:    return e_rt_val;
            SEL_DRS:    return d_rs_val;
            SEL_DRT:    return d_rt_val;
            SEL_WADDR:  return {27'd0, w_waddr};
            SEL_WPC:    return w_pc;
            default:    return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Monitor: timed observations plus in-order GRF write scoreboard.
    always @(negedge clk) begin
        for (int i = obs_q.size() - 1; i >= 0; i--) begin
            if (obs_q[i].cyc == cyc) begin
                mon_act = pick(obs_q[i].sel);
                checks++;
                if (mon_act !== obs_q[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %h, expected %h",
                             obs_q[i].name, cyc, mon_act, obs_q[i].exp);
                end
                obs_q.delete(i);
            end
        end
        if (w_reg_write === 1'b1) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected (cycle %0d): got write addr %0d pc %h, expected none",
                         cyc, w_waddr, w_pc);
            end else begin
                mon_wb = wb_q.pop_front();
                if (w_waddr !== mon_wb.addr || w_pc !== mon_wb.pc) begin
                    errors++;
                    $display("FAIL wb_write (cycle %0d): got addr %0d pc %h, expected addr %0d pc %h",
                             cyc, w_waddr, w_pc, mon_wb.addr, mon_wb.pc);
                end
            end
        end
    end

    task automatic expect_at(input int dcyc, input int sel, input logic [31:0] v,
                             input string nm);
        obs_t o;
        o.cyc  = cyc + dcyc;
        o.sel  = sel;
        o.exp  = v;
        o.name = nm;
        obs_q.push_back(o);
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] pc);
        wb_t w;
        w.addr = a;
        w.pc   = pc;
        wb_q.push_back(w);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [1:0] trs,
                         input logic [1:0] trt, input logic [4:0] dst,
                         input logic [1:0] tn);
        d_valid   = v;
        d_pc      = pc;
        d_rs      = rs;
        d_rt      = rt;
        d_tuse_rs = trs;
        d_tuse_rt = trt;
        d_dst     = dst;
        d_tnew    = tn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        e_res = '0;
        m_res = '0;
        w_res = '0;
        drive(1'b1, 32'h3000, 5'd1, 5'd2, 2'd0, 2'd0, 5'd1, 2'd0);
        tick();
        tick();

        // Reset released: nothing in flight
        reset = 1'b0;
        drive(1'b1, 32'h3000, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        expect_at(0, SEL_STALL,  32'd0, "rst_stall");
        expect_at(0, SEL_WRE,    32'd0, "rst_wre");
        expect_at(0, SEL_EVALID, 32'd0, "rst_evalid");
        expect_at(0, SEL_ERS,    32'd0, "rst_ers");
        tick();

        // ALU (dst 8, tnew 1) followed by branch on $8
        drive(1'b1, 32'h3004, 5'd1, 5'd2, 2'd3, 2'd3, 5'd8, 2'd1);
        expect_at(0, SEL_STALL, 32'd0, "alu_issue_stall");
        expect_wb(5'd8, 32'h3004);
        tick();
        drive(1'b1, 32'h3008, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        e_res = 32'h0000_9999;
        expect_at(0, SEL_STALL, 32'd1, "br_stall");
        tick();
        m_res = 32'h0000_1234;
        expect_at(0, SEL_STALL,  32'd0,          "br_release");
        expect_at(0, SEL_DRS,    32'h0000_1234,  "br_fwd_m");
        expect_at(0, SEL_EVALID, 32'd0,          "br_bubble");
        tick();

        // Load (dst 9, tnew 2) followed by use of $9 in E
        drive(1'b1, 32'h300C, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2);
        expect_at(0, SEL_STALL, 32'd0, "lw_issue_stall");
        expect_wb(5'd9, 32'h300C);
        tick();
        drive(1'b1, 32'h3010, 5'd0, 5'd9, 2'd3, 2'd1, 5'd10, 2'd1);
        expect_at(0, SEL_STALL, 32'd1, "lu_stall");
        tick();
        expect_at(0, SEL_STALL, 32'd0,          "lu_release");
        expect_at(0, SEL_DRT,   32'h1000_0009,  "lu_d_grf");
        expect_wb(5'd10, 32'h3010);
        tick();
        w_res = 32'hCAFE_BABE;
        m_res = 32'h5555_5555;
        expect_at(0, SEL_ERT,    32'hCAFE_BABE, "lu_e_fwd_w");
        expect_at(0, SEL_EVALID, 32'd1,         "lu_evalid");

        // Three writers of $5 back to back
        drive(1'b1, 32'h3014, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0);
        expect_wb(5'd5, 32'h3014);
        tick();
        drive(1'b1, 32'h3018, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0);
        expect_wb(5'd5, 32'h3018);
        tick();
        drive(1'b1, 32'h301C, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0);
        expect_wb(5'd5, 32'h301C);
        tick();
        e_res = 32'd1;
        m_res = 32'd2;
        w_res = 32'd3;
        drive(1'b1, 32'h3020, 5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0);
        expect_at(0, SEL_DRS,   32'd1, "prio_rs");
        expect_at(0, SEL_DRT,   32'd1, "prio_rt");
        expect_at(0, SEL_STALL, 32'd0, "prio_stall");
        tick();

        // $0 never forwards or stalls, even against dst 0 / tnew 2 producers
        drive(1'b1, 32'h3024, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
        tick();
        drive(1'b1, 32'h3028, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
        tick();
        drive(1'b1, 32'h302C, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        expect_at(0, SEL_DRS,   32'd0, "zero_rs");
        expect_at(0, SEL_DRT,   32'd0, "zero_rt");
        expect_at(0, SEL_STALL, 32'd0, "zero_stall");
        tick();

        // Writeback timing: dst 3 writes exactly 3 cycles after acceptance
        drive(1'b1, 32'h3004, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0);
        expect_wb(5'd3, 32'h3004);
        expect_at(1, SEL_WRE,   32'd0,      "wb_t1");
        expect_at(2, SEL_WRE,   32'd0,      "wb_t2");
        expect_at(3, SEL_WRE,   32'd1,      "wb_t3");
        expect_at(3, SEL_WADDR, 32'd3,      "wb_addr");
        expect_at(3, SEL_WPC,   32'h3004,   "wb_pc");
        tick();
        drive(1'b1, 32'h3030, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
        expect_at(3, SEL_WRE, 32'd0, "wb_dst0");
        tick();

        // Reset while a dst 4 / tnew 2 instruction sits in M
        drive(1'b1, 32'h3040, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2);
        tick();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h3050, 5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0);
        expect_at(0, SEL_STALL, 32'd0,         "mid_rst_stall");
        expect_at(0, SEL_DRS,   32'h1000_0004, "mid_rst_grf");
        expect_at(0, SEL_WRE,   32'd0,         "mid_rst_wre0");
        expect_at(1, SEL_WRE,   32'd0,         "mid_rst_wre1");
        expect_at(2, SEL_WRE,   32'd0,         "mid_rst_wre2");
        tick();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
        repeat (4) tick();

        checks++;
        if (wb_q.size() != 0) begin
            errors++;
            $display("FAIL wb_drain: got %0d writes still pending, expected 0", wb_q.size());
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL obs_drain: got %0d observations still pending, expected 0", obs_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
